// File: rtl/parity_pkg.sv
// Shared types for the serial parity frame checker: FSM states, parity modes
// and the parity-error helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // The accumulator holds the XOR of the payload bits.
  // Odd mode expects the total number of ones, including the parity bit, to be odd.
  function automatic logic parity_err(input logic acc, input logic pbit, input logic mode);
    return acc ^ pbit ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_W payload bits LSB first, then one parity bit.
// Reports the payload and parity result, and counts frames and parity errors.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              odd_mode,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              par_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_acc;
  logic              r_mode;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_par_err;
  logic              r_fv;
  logic              r_busy;
  logic              w_err_inc;

  // start is checked before the state decode so it aborts any frame in flight,
  // including one whose parity bit arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_acc     <= 1'b0;
      r_mode    <= PAR_EVEN;
      r_shift   <= '0;
      r_data    <= '0;
      r_par_err <= 1'b0;
      r_fv      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      if (start) begin
        r_state <= DATA;
        r_idx   <= '0;
        r_acc   <= 1'b0;
        r_mode  <= odd_mode;
        r_busy  <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
          end
          DATA: begin
            if (bit_valid) begin
              r_shift[r_idx] <= bit_in;
              r_acc          <= r_acc ^ bit_in;
              r_idx          <= r_idx + IDX_W'(1);
              if (r_idx == LAST_IDX) r_state <= PARITY;
            end
          end
          PARITY: begin
            if (bit_valid) begin
              r_data    <= r_shift;
              r_par_err <= parity_err(r_acc, bit_in, r_mode);
              r_fv      <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counters advance on the cycle after the frame_valid pulse, so a clr_cnt
  // held during that pulse competes directly with the increment.
  assign w_err_inc = r_fv & r_par_err;

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_fv),
    .clr   (clr_cnt),
    .cnt   (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_err_inc),
    .clr   (clr_cnt),
    .cnt   (err_cnt)
  );

  assign data_out    = r_data;
  assign frame_valid = r_fv;
  assign par_err     = r_par_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=8, CNT_W=2): vector table
// plus hand sequences for saturation, clear priority, aborts and reset.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, bit_in, bit_valid, odd_mode, clr_cnt;
  logic [7:0] data_out;
  logic       frame_valid, par_err, busy;
  logic [1:0] frame_cnt, err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;
  int exp_ec = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_err  = 1'b0;

  typedef struct {
    logic       odd;
    logic [7:0] payload;
    logic       pbit;
    logic       gap;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  parity_frame_checker #(.DATA_W(8), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .odd_mode    (odd_mode),
    .clr_cnt     (clr_cnt),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .par_err     (par_err),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
    check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_ec));
  endtask

  task automatic do_clr();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    exp_fc = 0;
    exp_ec = 0;
    check_counts("clr");
  endtask

  // Called at a negedge. Asserts start now; returns at the frame_valid
  // negedge (tail=0) or one negedge later after checking counters (tail=1).
  task automatic send_frame(input logic odd, input logic [7:0] pl, input logic pb,
                            input logic gap, input logic exp_err,
                            input logic tail, input logic clr_on_fv);
    start = 1'b1; odd_mode = odd; bit_valid = 1'b1; bit_in = ~pl[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
      if (gap) begin
        bit_valid = 1'b0;
        @(negedge clk);
      end
      bit_valid = 1'b1; bit_in = pl[i];
    end
    @(negedge clk);
    if (gap) begin
      bit_valid = 1'b0;
      @(negedge clk);
    end
    check("fv_early", 32'(frame_valid), 32'd0);
    bit_valid = 1'b1; bit_in = pb;
    @(negedge clk);
    bit_valid = 1'b0;
    check("fv_pulse", 32'(frame_valid), 32'd1);
    check("data_out", 32'(data_out), 32'(pl));
    check("par_err", 32'(par_err), 32'(exp_err));
    check("busy_done", 32'(busy), 32'd0);
    last_data = pl;
    last_err  = exp_err;
    if (clr_on_fv) begin
      clr_cnt = 1'b1;
      exp_fc = 0;
      exp_ec = 0;
    end else begin
      if (exp_fc < 3) exp_fc++;
      if (exp_err && exp_ec < 3) exp_ec++;
    end
    if (tail) begin
      @(negedge clk);
      clr_cnt = 1'b0;
      check("fv_one_cycle", 32'(frame_valid), 32'd0);
      check_counts("frame");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    odd_mode = 1'b0; clr_cnt = 1'b0;

    //            odd   payload pbit  gap   exp_err
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_counts("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      send_frame(vecs[v].odd, vecs[v].payload, vecs[v].pbit, vecs[v].gap,
                 vecs[v].exp_err, 1'b1, 1'b0);

    // Saturation of both 2-bit counters, then clear racing frame_valid.
    do_clr();
    for (int k = 0; k < 5; k++)
      send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_err_cnt", 32'(err_cnt), 32'd3);
    check("sat_frame_cnt", 32'(frame_cnt), 32'd3);
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Back-to-back: next start issued in the previous frame's frame_valid cycle.
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Abort after 4 bits, then a full 0x81 frame.
    do_clr();
    start = 1'b1; odd_mode = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; bit_in = i[0];
      @(negedge clk);
      check("abort4_no_fv", 32'(frame_valid), 32'd0);
    end
    check("abort4_hold_data", 32'(data_out), 32'(last_data));
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort4_frame_cnt", 32'(frame_cnt), 32'd1);

    // start coincident with the parity sample aborts the frame.
    start = 1'b1; odd_mode = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b1; bit_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0;
    check("par_abort_no_fv", 32'(frame_valid), 32'd0);
    check("par_abort_busy", 32'(busy), 32'd1);
    check("par_abort_hold_data", 32'(data_out), 32'(last_data));
    @(negedge clk);
    check("par_abort_no_fv2", 32'(frame_valid), 32'd0);
    check_counts("par_abort");

    // Reset mid-frame after 5 bits.
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1; odd_mode = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    check("async_rst_fcnt", 32'(frame_cnt), 32'd0);
    exp_fc = 0; exp_ec = 0; last_data = 8'h00; last_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_fv", 32'(frame_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the frame and error counters.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, width 1: a pulse that begins a new frame.
REQ-006 The block SHALL have port bit_in, input, width 1: serial data, LSB first, followed by the parity bit.
REQ-007 The block SHALL have port bit_valid, input, width 1: bit_in is sampled only when this is 1.
REQ-008 The block SHALL have port odd_mode, input, width 1: 0 selects even parity, 1 selects odd parity; sampled on start.
REQ-009 The block SHALL have port clr_cnt, input, width 1: synchronous clear of both counters.
REQ-010 The block SHALL have port data_out, output, width DATA_W: the last completed payload.
REQ-011 The block SHALL have port frame_valid, output, width 1: a one-cycle pulse when a frame completes.
REQ-012 The block SHALL have port par_err, output, width 1: the parity result of the last frame, held until the next frame completes.
REQ-013 The block SHALL have port busy, output, width 1: high in states DATA and PARITY.
REQ-014 The block SHALL have port frame_cnt, output, width CNT_W: the number of completed frames, saturating.
REQ-015 The block SHALL have port err_cnt, output, width CNT_W: the number of frames with par_err=1, saturating.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, DATA and PARITY.
REQ-017 In IDLE, start=1 SHALL cause the following on the next edge:
- move to DATA;
- clear the bit index and the parity accumulator to 0;
- latch odd_mode into mode_q.
REQ-018 bit_valid in the cycle in which start is accepted SHALL be ignored; the first data bit is sampled the cycle after.
REQ-019 In DATA, each bit_valid=1 cycle SHALL do the following:
- store bit_in at shift position index (LSB first);
- XOR bit_in into the accumulator;
- increment the index.
REQ-020 Sampling bit DATA_W-1 SHALL move the FSM to PARITY.
REQ-021 Cycles with bit_valid=0 SHALL hold all state, with no timeout.
REQ-022 In PARITY, bit_valid=1 SHALL compute err = acc XOR bit_in XOR mode_q.
REQ-023 On the next edge after the PARITY sample, the block SHALL do the following:
- register the payload to data_out and err to par_err;
- pulse frame_valid for one cycle;
- return to IDLE.
REQ-024 Latency from the parity-bit sample edge to frame_valid=1 SHALL be 1 cycle.
REQ-025 frame_cnt SHALL increment by 1 on every frame_valid.
REQ-026 err_cnt SHALL increment by 1 on every frame_valid with err=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_cnt=1 SHALL zero both counters on the next edge, taking priority over a simultaneous increment.
REQ-029 start=1 in DATA or PARITY SHALL abort the current frame and restart per REQ-017.
REQ-030 An aborted frame SHALL produce no frame_valid, leave the counters unchanged, and hold data_out/par_err.
REQ-031 start=1 in the same cycle as the parity sample SHALL take priority: the frame is aborted and no frame_valid is produced.
REQ-032 A new start SHALL be accepted in IDLE the cycle after PARITY (back-to-back frames), with frame_valid of the previous frame occurring in that same cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force the FSM to IDLE.
REQ-034 rst_n=0 SHALL immediately clear data_out, par_err, frame_valid, busy, frame_cnt, err_cnt, the accumulator, the index and mode_q to 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame, with no output pulse after release.
REQ-036 After rst_n deasserts, the first accepted start SHALL be on a clock edge with rst_n=1.

Structure
REQ-037 A shared package parity_pkg SHALL hold:
- the state enum (IDLE, DATA, PARITY);
- constants PAR_EVEN=0 and PAR_ODD=1.
REQ-038 A sub-module sat_counter (parameter W; inputs inc, clr; clr has priority) SHALL be used, instantiated twice, for frame_cnt and err_cnt.
REQ-039 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-040 Even mode, DATA_W=8, payload 0xA5 then parity 0 -> data_out=0xA5, par_err=0, frame_cnt=1, err_cnt=0.
REQ-041 Even mode, payload 0xA5 then parity 1 -> par_err=1, err_cnt=1; odd mode, payload 0xA5 then parity 1 -> par_err=0.
REQ-042 Payload 0x3C with bit_valid low on alternate cycles -> frame_valid exactly once, 1 cycle after the parity sample, data_out=0x3C.
REQ-043 With CNT_W=2, five error frames -> err_cnt=3 and frame_cnt=3; clr_cnt on the same cycle as a sixth frame's frame_valid -> both counters 0.
REQ-044 start after 4 bits of frame A, then full frame 0x81 with parity 0 (even mode) -> a single frame_valid, data_out=0x81, frame_cnt=1.
REQ-045 rst_n pulsed low after 5 bits -> busy=0 immediately, no frame_valid, and the next full frame checks correctly.
